// File: rtl/core_decode_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_decode_buffer_pkg
// Description : Shared micro-architecture types for the decode buffer:
//               the insn_decode entry layout, the all-zero bubble constant
//               and the default buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package core_decode_buffer_pkg;

   typedef logic [31:0] word;
   typedef logic [15:0] hword;
   typedef logic [4:0]  reg_num;

   typedef struct packed {
      logic       execute;   // dispatch starts a unit only when set
      logic [3:0] alu;       // ALU operation select
   } insn_ctrl;

   typedef struct packed {
      word      pc;
      reg_num   rd;
      reg_num   rs1;
      reg_num   rs2;
      hword     imm;
      insn_ctrl ctrl;
   } insn_decode;

   localparam int         DECBUF_DEPTH = 8;
   localparam insn_decode NOP_DECODE   = '0;

endpackage : core_decode_buffer_pkg
`default_nettype wire

// File: rtl/core_decode_buffer_ptrs.sv
`default_nettype none
// ============================================================================
// Module      : core_decode_buffer_ptrs
// Description : Pointer / occupancy bookkeeping for the decode buffer.
//               Computes the number of entries written (0..2) and popped
//               (0..2) each cycle, the read/write pointers and in_ready_o.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid_i            - per-slot push valid (bit0 = in_a)
//               stall_i, flush_i      - dispatch stall, redirect flush
//               byp_n_i               - incoming entries consumed by bypass
//               rd_ptr_o, wr_ptr_o    - circular-array pointers
//               count_o               - current occupancy
//               in_ready_o            - at least two free slots
//               wr_n_o                - entries written to storage this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module core_decode_buffer_ptrs #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               in_valid_i,
   input  logic                     stall_i,
   input  logic                     flush_i,
   input  logic [1:0]               byp_n_i,
   output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
   output logic [$clog2(DEPTH)-1:0] wr_ptr_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     in_ready_o,
   output logic [1:0]               wr_n_o
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_CNT_W-1:0] count_q,  count_d;
   logic [1:0]         w_n_in;
   logic [1:0]         w_pop_n;

   // Ready looks at the current count only; a same-cycle pop is not credited.
   assign in_ready_o = (count_q <= c_CNT_W'(DEPTH - 2));

   always_comb begin
      w_n_in  = {1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]};
      wr_n_o  = (in_ready_o && !flush_i) ? (w_n_in - byp_n_i) : 2'd0;
      w_pop_n = 2'd0;
      if (!stall_i && !flush_i) begin
         w_pop_n = (count_q >= c_CNT_W'(2)) ? 2'd2 : count_q[1:0];
      end
      rd_ptr_d = rd_ptr_q + c_PTR_W'(w_pop_n);
      wr_ptr_d = wr_ptr_q + c_PTR_W'(wr_n_o);
      count_d  = count_q + c_CNT_W'(wr_n_o) - c_CNT_W'(w_pop_n);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_ptr_o = rd_ptr_q;
   assign wr_ptr_o = wr_ptr_q;
   assign count_o  = count_q;

endmodule : core_decode_buffer_ptrs
`default_nettype wire

// File: rtl/core_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module      : core_decode_buffer
// Description : Decoded-instruction queue feeding dual-issue dispatch.
//               Accepts up to two entries per cycle, presents the two oldest
//               in program order (bubbles when empty), pops them when
//               dispatch does not stall, and empties on flush.
//               Optional macro CORE_DECBUF_BYPASS_EN adds a same-cycle path
//               from the inputs to dec_a_o/dec_b_o when the buffer holds
//               fewer than two entries.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_a_i, in_b_i        - older / younger incoming entries
//               in_valid_i            - bit0 = in_a_i valid, bit1 = in_b_i
//               in_ready_o            - push accepted this cycle
//               stall_i               - dispatch stall
//               flush_i               - discard all contents
//               dec_a_o, dec_b_o      - oldest / second-oldest or bubble
//               count_o               - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module core_decode_buffer
   import core_decode_buffer_pkg::*;
#(
   parameter int DEPTH = DECBUF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  insn_decode             in_a_i,
   input  insn_decode             in_b_i,
   input  logic [1:0]             in_valid_i,
   output logic                   in_ready_o,
   input  logic                   stall_i,
   input  logic                   flush_i,
   output insn_decode             dec_a_o,
   output insn_decode             dec_b_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   insn_decode         mem_q [DEPTH];
   logic [c_PTR_W-1:0] w_rd_ptr;
   logic [c_PTR_W-1:0] w_wr_ptr;
   logic [c_CNT_W-1:0] w_count;
   logic [1:0]         w_wr_n;
   logic [1:0]         w_byp_n;
   logic [1:0]         w_n_in;
   insn_decode         w_first;
   insn_decode         w_wr0;

   // Incoming entries compacted into program order: in_valid=2'b10 makes
   // in_b the first (and only) incoming entry.
   assign w_n_in  = {1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]};
   assign w_first = in_valid_i[0] ? in_a_i : in_b_i;

   // Entries taken by the bypass are skipped; a second write only happens
   // when nothing was bypassed, so it is always in_b.
   assign w_wr0 = (w_byp_n == 2'd0) ? w_first : in_b_i;

`ifdef CORE_DECBUF_BYPASS_EN
   logic [1:0] w_byp_cap;
   always_comb begin
      w_byp_cap = (w_count == c_CNT_W'(0)) ? 2'd2 : 2'd1;
      w_byp_n   = 2'd0;
      if (!stall_i && !flush_i && (w_count < c_CNT_W'(2))) begin
         w_byp_n = (w_n_in < w_byp_cap) ? w_n_in : w_byp_cap;
      end
   end
`else
   assign w_byp_n = 2'd0;
`endif

   core_decode_buffer_ptrs #(
      .DEPTH (DEPTH)
   ) u_ptrs (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid_i),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .byp_n_i    (w_byp_n),
      .rd_ptr_o   (w_rd_ptr),
      .wr_ptr_o   (w_wr_ptr),
      .count_o    (w_count),
      .in_ready_o (in_ready_o),
      .wr_n_o     (w_wr_n)
   );

   // Storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (w_wr_n != 2'd0) begin
         mem_q[w_wr_ptr] <= w_wr0;
      end
      if (w_wr_n == 2'd2) begin
         mem_q[w_wr_ptr + c_PTR_W'(1)] <= in_b_i;
      end
   end

   always_comb begin
      dec_a_o = NOP_DECODE;
      dec_b_o = NOP_DECODE;
      if (w_count >= c_CNT_W'(1)) dec_a_o = mem_q[w_rd_ptr];
      if (w_count >= c_CNT_W'(2)) dec_b_o = mem_q[w_rd_ptr + c_PTR_W'(1)];
`ifdef CORE_DECBUF_BYPASS_EN
      // Incoming entries fill whichever presented slots storage leaves empty.
      if (!flush_i) begin
         if (w_count == c_CNT_W'(0)) begin
            if (w_n_in != 2'd0) dec_a_o = w_first;
            if (w_n_in == 2'd2) dec_b_o = in_b_i;
         end else if (w_count == c_CNT_W'(1)) begin
            if (w_n_in != 2'd0) dec_b_o = w_first;
         end
      end
`endif
   end

   assign count_o = w_count;

endmodule : core_decode_buffer
`default_nettype wire

// File: tb/tb_core_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_decode_buffer
// Description : Self-checking bench for core_decode_buffer. A queue-based
//               reference model predicts dec_a/dec_b, count and in_ready
//               for directed sequences and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_decode_buffer;
   import core_decode_buffer_pkg::*;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   insn_decode in_a, in_b, dec_a, dec_b;
   logic [1:0] in_valid;
   logic       in_ready, stall, flush;
   logic [$clog2(DEPTH):0] count;

   int n_tests = 0;
   int n_fail  = 0;
   int pc_seq  = 32'h100;

   insn_decode q[$];   // reference contents, oldest first

   core_decode_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_a_i     (in_a),
      .in_b_i     (in_b),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .stall_i    (stall),
      .flush_i    (flush),
      .dec_a_o    (dec_a),
      .dec_b_o    (dec_b),
      .count_o    (count)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [127:0] obs,
                              input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic insn_decode mk(input int pc);
      insn_decode d;
      d            = '0;
      d.pc         = word'(pc);
      d.rd         = reg_num'($urandom);
      d.rs1        = reg_num'($urandom);
      d.rs2        = reg_num'($urandom);
      d.imm        = hword'($urandom);
      d.ctrl.execute = 1'b1;
      d.ctrl.alu   = 4'($urandom);
      return d;
   endfunction

   // One cycle: drive inputs after the falling edge, compare predictions,
   // then advance the reference model across the rising edge.
   task automatic step(input logic [1:0] v, input insn_decode a,
                       input insn_decode b, input logic s, input logic f);
      insn_decode inc[$];
      insn_decode view[$];
      insn_decode ea, eb;
      int         sz, npop;
      bit         rdy;
      @(negedge clk);
      in_valid = v; in_a = a; in_b = b; stall = s; flush = f;
      #1;
      inc = {};
      if (v[0]) inc.push_back(a);
      if (v[1]) inc.push_back(b);
      sz  = q.size();
      rdy = (DEPTH - sz) >= 2;
      view = q;
`ifdef CORE_DECBUF_BYPASS_EN
      // Accepted inputs behave as if already queued behind the contents.
      if (rdy && !f) foreach (inc[i]) view.push_back(inc[i]);
`endif
      ea = (view.size() >= 1) ? view[0] : NOP_DECODE;
      eb = (view.size() >= 2) ? view[1] : NOP_DECODE;
      check_value("dec_a", 128'(dec_a), 128'(ea));
      check_value("dec_b", 128'(dec_b), 128'(eb));
      check_value("count", 128'(count), 128'(sz));
      check_value("in_ready", 128'(in_ready), 128'(rdy));
      if (f) begin
         q.delete();
      end else begin
`ifdef CORE_DECBUF_BYPASS_EN
         npop = s ? 0 : ((view.size() < 2) ? view.size() : 2);
         repeat (npop) void'(view.pop_front());
         q = view;
`else
         npop = s ? 0 : ((sz < 2) ? sz : 2);
         repeat (npop) void'(q.pop_front());
         if (rdy) foreach (inc[i]) q.push_back(inc[i]);
`endif
      end
      @(posedge clk);
   endtask

   task automatic idle(input logic s);
      step(2'b00, NOP_DECODE, NOP_DECODE, s, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 2'b00; in_a = '0; in_b = '0;
      stall = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_count", 128'(count), 128'(0));
      check_value("rst_ready", 128'(in_ready), 128'(1));
      check_value("rst_dec_a", 128'(dec_a), 128'(NOP_DECODE));
      check_value("rst_dec_b", 128'(dec_b), 128'(NOP_DECODE));
      rst_n = 1'b1;

      // Pair push and drain.
      step(2'b11, mk(32'h10), mk(32'h11), 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      // Single push, second slot a bubble, no underflow.
      step(2'b01, mk(32'h20), NOP_DECODE, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      // in_b alone.
      step(2'b10, NOP_DECODE, mk(32'h28), 1'b0, 1'b0);
      idle(1'b0);
      // Fill under stall until full; extra pushes dropped.
      for (int i = 0; i < 6; i++)
         step(2'b11, mk(32'h40 + 2*i), mk(32'h41 + 2*i), 1'b1, 1'b0);
      // Drain to 6, then push 2 / pop 2 across pointer wrap.
      idle(1'b0);
      step(2'b11, mk(32'h60), mk(32'h61), 1'b1, 1'b0);
      step(2'b11, mk(32'h62), mk(32'h63), 1'b0, 1'b0);
      step(2'b11, mk(32'h64), mk(32'h65), 1'b0, 1'b0);
      repeat (4) idle(1'b0);
      // Flush at count 5 with a simultaneous push.
      step(2'b11, mk(32'h70), mk(32'h71), 1'b1, 1'b0);
      step(2'b11, mk(32'h72), mk(32'h73), 1'b1, 1'b0);
      step(2'b01, mk(32'h74), NOP_DECODE, 1'b1, 1'b0);
      step(2'b11, mk(32'h75), mk(32'h76), 1'b0, 1'b1);
      idle(1'b1);
      // Push into empty buffer without stall (bypass case when enabled).
      step(2'b11, mk(32'h30), mk(32'h31), 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic [1:0] v;
         logic       s, f;
         v = 2'($urandom);
         s = ($urandom_range(0, 1) == 0);
         f = ($urandom_range(0, 24) == 0);
         step(v, mk(pc_seq), mk(pc_seq + 1), s, f);
         pc_seq += 2;
      end

      // Asynchronous reset in the middle of a cycle.
      for (int i = 0; i < 3; i++)
         step(2'b11, mk(32'h90 + 2*i), mk(32'h91 + 2*i), 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 2'b00;
      #2 rst_n = 1'b0;
      #1;
      check_value("arst_count", 128'(count), 128'(0));
      check_value("arst_dec_a", 128'(dec_a), 128'(NOP_DECODE));
      check_value("arst_ready", 128'(in_ready), 128'(1));
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(2'b11, mk(32'hA0), mk(32'hA1), 1'b0, 1'b0);
      idle(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Overall time bound.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule : tb_core_decode_buffer
`default_nettype wire
